// File: rtl/fifo_rr_arb.sv
// fifo_rr_arb: round-robin arbiter that drains NUM_CH show-ahead FIFOs into a
// single registered output stage. In PKT_MODE=1 the grant is held on one channel
// from the first word of a packet until the word carrying the last flag
// (bit DATAWIDTH-1) has been popped.
//
// State table
//   state    | meaning
//   S_IDLE   | free to arbitrate among enabled, unmasked, non-empty channels
//   S_LOCKED | mid-packet; only lock_ch may be popped
//
// Ports
//   clk       input   clock, all state changes on rising edge
//   reset_l   input   asynchronous active-low reset
//   enable    input   permits new packet starts
//   ch_mask   input   per-channel eligibility (1 = eligible)
//   ch_ne     input   per-channel FIFO not-empty
//   ch_data   input   head-of-FIFO words, channel i at [i*DATAWIDTH +: DATAWIDTH]
//   ch_re     output  pop strobes, combinational, one-hot or zero
//   out_data  output  registered forwarded word
//   out_ch    output  registered source channel of out_data
//   out_valid output  out_data/out_ch valid
//   out_ready input   downstream accept
//   locked    output  packet in progress
`timescale 1ns/1ps

module fifo_rr_arb #(
  parameter int NUM_CH    = 4,
  parameter int DATAWIDTH = 18,
  parameter int PKT_MODE  = 1,
  parameter int CHW       = 2
) (
  input  logic                        clk,
  input  logic                        reset_l,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           ch_mask,
  input  logic [NUM_CH-1:0]           ch_ne,
  input  logic [NUM_CH*DATAWIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]           ch_re,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic [CHW-1:0]              out_ch,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        locked
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                state, state_nxt;
  logic [CHW-1:0]        lock_ch, lock_ch_nxt;
  logic [CHW-1:0]        last_grant;
  logic [CHW-1:0]        grant;
  logic [CHW-1:0]        scan_idx;
  logic                  grant_vld;
  logic [NUM_CH-1:0]     cand;
  logic                  slot_free;
  logic                  pop;
  logic [DATAWIDTH-1:0]  pop_word;
  logic [DATAWIDTH-1:0]  ch_word [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_word[g] = ch_data[g*DATAWIDTH +: DATAWIDTH];
  end

  assign slot_free = !out_valid || out_ready;

  // Candidate set and round-robin scan. The loop runs from the farthest
  // position back to last_grant+1 so the nearest candidate is written last
  // and wins.
  always_comb begin
    cand      = '0;
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    if (state == S_LOCKED) begin
      if (ch_ne[lock_ch]) cand[lock_ch] = 1'b1;
    end else if (enable) begin
      cand = ch_ne & ch_mask;
    end
    for (int i = NUM_CH; i >= 1; i--) begin
      scan_idx = CHW'((int'(last_grant) + i) % NUM_CH);
      if (cand[scan_idx]) begin
        grant_vld = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  assign pop      = grant_vld && slot_free;
  assign pop_word = ch_word[grant];

  // Gated by reset_l so no FIFO is popped while the output stage is held in reset.
  always_comb begin
    ch_re = '0;
    if (pop && reset_l) ch_re[grant] = 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    case (state)
      S_IDLE: begin
        if (PKT_MODE != 0 && pop && !pop_word[DATAWIDTH-1]) begin
          state_nxt   = S_LOCKED;
          lock_ch_nxt = grant;
        end
      end
      S_LOCKED: begin
        // Only lock_ch can be a candidate here, so any pop is from lock_ch.
        if (pop && pop_word[DATAWIDTH-1]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= S_IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      out_data   <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
      last_grant <= CHW'(NUM_CH - 1);
    end else if (pop) begin
      out_data   <= pop_word;
      out_ch     <= grant;
      out_valid  <= 1'b1;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_fifo_rr_arb.sv
`timescale 1ns/1ps

module tb_fifo_rr_arb;

  localparam int NC = 4;
  localparam int DW = 18;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_l = 1'b1;
  logic            enable = 1'b1;
  logic [NC-1:0]   ch_mask = '1;
  logic [NC-1:0]   ch_ne = '0;
  logic [NC*DW-1:0] ch_data = '0;
  logic            out_ready = 1'b1;

  logic [NC-1:0]   re_a, re_b;
  logic [DW-1:0]   od_a, od_b;
  logic [1:0]      och_a, och_b;
  logic            ov_a, ov_b, lk_a, lk_b;

  logic [DW-1:0]   fq [NC][$];
  exp_t            exp_q[$];
  logic [NC-1:0]   gap = '0;
  logic            use_b = 1'b0;
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  fifo_rr_arb #(.NUM_CH(NC), .DATAWIDTH(DW), .PKT_MODE(1), .CHW(2)) dut_a (
    .clk(clk), .reset_l(reset_l), .enable(enable), .ch_mask(ch_mask),
    .ch_ne(ch_ne), .ch_data(ch_data), .ch_re(re_a), .out_data(od_a),
    .out_ch(och_a), .out_valid(ov_a), .out_ready(out_ready), .locked(lk_a));

  fifo_rr_arb #(.NUM_CH(NC), .DATAWIDTH(DW), .PKT_MODE(0), .CHW(2)) dut_b (
    .clk(clk), .reset_l(reset_l), .enable(enable), .ch_mask(ch_mask),
    .ch_ne(ch_ne), .ch_data(ch_data), .ch_re(re_b), .out_data(od_b),
    .out_ch(och_b), .out_valid(ov_b), .out_ready(out_ready), .locked(lk_b));

  function automatic logic [DW-1:0] mk(input bit last, input int ch, input int n);
    return {last, 1'b0, 8'(ch), 8'(n)};
  endfunction

  task automatic refresh();
    for (int i = 0; i < NC; i++) begin
      ch_ne[i] = (fq[i].size() != 0) && !gap[i];
      ch_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic expect_word(input int ch, input logic [DW-1:0] w);
    exp_t e;
    e.ch = 2'(ch);
    e.d  = w;
    exp_q.push_back(e);
  endtask

  // One clock: sample at the falling edge (pop legality, output scoreboard),
  // then let the rising edge happen and retire popped words from the FIFO model.
  task automatic step(output logic [NC-1:0] re);
    logic [DW-1:0] od;
    logic [1:0]    och;
    logic          ov;
    exp_t          e;
    @(negedge clk);
    re  = use_b ? re_b : re_a;
    od  = use_b ? od_b : od_a;
    och = use_b ? och_b : och_a;
    ov  = use_b ? ov_b : ov_a;
    total++;
    if ($countones(re) > 1 || (re & ~ch_ne) != '0) begin
      bad++;
      $display("FAIL re_legal: ch_re=%b ch_ne=%b (want at most one bit, only non-empty)", re, ch_ne);
    end
    if (ov && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got ch=%0d data=%h, scoreboard empty", och, od);
      end else begin
        e = exp_q.pop_front();
        if ({och, od} !== {e.ch, e.d}) begin
          bad++;
          $display("FAIL out_word: got ch=%0d data=%h want ch=%0d data=%h", och, od, e.ch, e.d);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++)
      if (re[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    refresh();
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d words still expected, want 0", name, exp_q.size());
    end
  endtask

  task automatic reset_dut();
    reset_l = 1'b0;
    for (int i = 0; i < NC; i++) fq[i].delete();
    exp_q.delete();
    gap = '0; enable = 1'b1; ch_mask = '1; out_ready = 1'b1; use_b = 1'b0;
    refresh();
    @(posedge clk); #1;
    reset_l = 1'b1;
  endtask

  task automatic test_reset();
    logic [NC-1:0] re;
    #1 reset_l = 1'b0;
    fq[1].push_back(mk(1, 1, 0));
    fq[2].push_back(mk(1, 2, 0));
    refresh();
    #2;
    total++;
    if ({ov_a, lk_a, och_a, od_a} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b locked=%b ch=%0d data=%h want all 0", ov_a, lk_a, och_a, od_a);
    end
    total++;
    if (re_a !== '0) begin
      bad++;
      $display("FAIL reset_re: ch_re=%b want 0000", re_a);
    end
    @(posedge clk); #1;
    reset_l = 1'b1;
    expect_word(1, mk(1, 1, 0));
    expect_word(2, mk(1, 2, 0));
    step(re);
    total++;
    if (re !== 4'b0010) begin bad++; $display("FAIL reset_first_grant: ch_re=%b want 0010", re); end
    step(re);
    total++;
    if (re !== 4'b0100) begin bad++; $display("FAIL reset_second_grant: ch_re=%b want 0100", re); end
    step(re);
    check_drained("reset");
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] re;
    int seq[5] = '{0, 1, 2, 3, 0};
    reset_dut();
    fq[0].push_back(mk(1, 0, 0));
    fq[0].push_back(mk(1, 0, 1));
    for (int i = 1; i < NC; i++) fq[i].push_back(mk(1, i, 0));
    refresh();
    expect_word(0, mk(1, 0, 0)); expect_word(1, mk(1, 1, 0));
    expect_word(2, mk(1, 2, 0)); expect_word(3, mk(1, 3, 0));
    expect_word(0, mk(1, 0, 1));
    for (int k = 0; k < 5; k++) begin
      step(re);
      total++;
      if (re !== (4'b0001 << seq[k])) begin
        bad++;
        $display("FAIL rr_grant[%0d]: ch_re=%b want ch%0d", k, re, seq[k]);
      end
      total++;
      if ({ov_a, och_a} !== {1'b1, 2'(seq[k])}) begin
        bad++;
        $display("FAIL rr_out_ch[%0d]: valid=%b ch=%0d want valid=1 ch=%0d", k, ov_a, och_a, seq[k]);
      end
    end
    step(re);
    total++;
    if (re !== '0) begin bad++; $display("FAIL rr_idle: ch_re=%b want 0000", re); end
    check_drained("rr");
  endtask

  task automatic test_packet();
    logic [NC-1:0] re;
    int seq[5]   = '{1, 1, 1, 2, 0};
    bit exp_lk[5] = '{1, 1, 0, 0, 0};
    reset_dut();
    fq[0].push_back(mk(1, 0, 0));
    refresh();
    expect_word(0, mk(1, 0, 0));
    step(re);
    total++;
    if (re !== 4'b0001) begin bad++; $display("FAIL pkt_pre: ch_re=%b want 0001", re); end
    fq[1].push_back(mk(0, 1, 0));
    fq[1].push_back(mk(0, 1, 1));
    fq[1].push_back(mk(1, 1, 2));
    fq[2].push_back(mk(1, 2, 0));
    fq[0].push_back(mk(1, 0, 1));
    refresh();
    expect_word(1, mk(0, 1, 0)); expect_word(1, mk(0, 1, 1)); expect_word(1, mk(1, 1, 2));
    expect_word(2, mk(1, 2, 0)); expect_word(0, mk(1, 0, 1));
    for (int k = 0; k < 5; k++) begin
      step(re);
      total++;
      if (re !== (4'b0001 << seq[k])) begin
        bad++;
        $display("FAIL pkt_grant[%0d]: ch_re=%b want ch%0d", k, re, seq[k]);
      end
      total++;
      if (lk_a !== exp_lk[k]) begin
        bad++;
        $display("FAIL pkt_locked[%0d]: locked=%b want %b", k, lk_a, exp_lk[k]);
      end
    end
    step(re);
    check_drained("pkt");
  endtask

  task automatic test_backpressure();
    logic [NC-1:0] re;
    logic [DW-1:0] hold;
    reset_dut();
    for (int n = 0; n < 3; n++) begin
      fq[0].push_back(mk(1, 0, n));
      fq[1].push_back(mk(1, 1, n));
      expect_word(0, mk(1, 0, n));
      expect_word(1, mk(1, 1, n));
    end
    refresh();
    step(re);
    total++;
    if (re !== 4'b0001) begin bad++; $display("FAIL bp_first: ch_re=%b want 0001", re); end
    out_ready = 1'b0;
    hold = mk(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(re);
      total++;
      if (re !== '0) begin bad++; $display("FAIL bp_re[%0d]: ch_re=%b want 0000", k, re); end
      total++;
      if ({ov_a, och_a, od_a} !== {1'b1, 2'd0, hold}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b ch=%0d data=%h want 1/0/%h", k, ov_a, och_a, od_a, hold);
      end
    end
    out_ready = 1'b1;
    step(re);
    total++;
    if (re !== 4'b0010) begin bad++; $display("FAIL bp_resume: ch_re=%b want 0010", re); end
    for (int k = 0; k < 5; k++) step(re);
    check_drained("bp");
  endtask

  task automatic test_stall();
    logic [NC-1:0] re;
    reset_dut();
    fq[0].push_back(mk(1, 0, 0));
    fq[0].push_back(mk(1, 0, 1));
    for (int n = 0; n < 4; n++) fq[3].push_back(mk(n == 3, 3, n));
    refresh();
    expect_word(0, mk(1, 0, 0));
    for (int n = 0; n < 4; n++) expect_word(3, mk(n == 3, 3, n));
    expect_word(0, mk(1, 0, 1));
    step(re);
    total++;
    if (re !== 4'b0001) begin bad++; $display("FAIL stall_g0: ch_re=%b want 0001", re); end
    step(re);
    total++;
    if (re !== 4'b1000) begin bad++; $display("FAIL stall_g1: ch_re=%b want 1000", re); end
    gap[3] = 1'b1;
    refresh();
    for (int k = 0; k < 4; k++) begin
      step(re);
      total++;
      if (re !== '0 || lk_a !== 1'b1) begin
        bad++;
        $display("FAIL stall_gap[%0d]: ch_re=%b locked=%b want 0000/1", k, re, lk_a);
      end
    end
    gap[3] = 1'b0;
    refresh();
    for (int k = 0; k < 3; k++) begin
      step(re);
      total++;
      if (re !== 4'b1000) begin bad++; $display("FAIL stall_resume[%0d]: ch_re=%b want 1000", k, re); end
    end
    step(re);
    total++;
    if (re !== 4'b0001) begin bad++; $display("FAIL stall_after: ch_re=%b want 0001", re); end
    step(re);
    check_drained("stall");
  endtask

  task automatic test_async_reset();
    logic [NC-1:0] re;
    int seq[3] = '{0, 1, 2};
    reset_dut();
    for (int n = 0; n < 3; n++) fq[2].push_back(mk(n == 2, 2, n));
    refresh();
    expect_word(2, mk(0, 2, 0));
    step(re);
    step(re);
    total++;
    if (re !== 4'b0100 || lk_a !== 1'b1) begin
      bad++;
      $display("FAIL ar_setup: ch_re=%b locked=%b want 0100/1", re, lk_a);
    end
    #2 reset_l = 1'b0;
    #1;
    total++;
    if ({ov_a, lk_a} !== 2'b00) begin
      bad++;
      $display("FAIL ar_immediate: valid=%b locked=%b want 0/0", ov_a, lk_a);
    end
    total++;
    if (re_a !== '0) begin bad++; $display("FAIL ar_re: ch_re=%b want 0000", re_a); end
    fq[0].push_back(mk(1, 0, 9));
    fq[1].push_back(mk(1, 1, 9));
    refresh();
    expect_word(0, mk(1, 0, 9)); expect_word(1, mk(1, 1, 9)); expect_word(2, mk(1, 2, 2));
    @(posedge clk); #1;
    reset_l = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(re);
      total++;
      if (re !== (4'b0001 << seq[k])) begin
        bad++;
        $display("FAIL ar_grant[%0d]: ch_re=%b want ch%0d", k, re, seq[k]);
      end
    end
    total++;
    if (lk_a !== 1'b0) begin bad++; $display("FAIL ar_single_word: locked=%b want 0", lk_a); end
    step(re);
    check_drained("ar");
  endtask

  task automatic test_mask_enable();
    logic [NC-1:0] re;
    int seq[8] = '{0, 2, 0, 2, 3, 1, 3, 1};
    reset_dut();
    use_b = 1'b1;
    enable = 1'b0;
    ch_mask = 4'b0101;
    for (int i = 0; i < NC; i++)
      for (int n = 0; n < 2; n++) fq[i].push_back(mk(0, i, n));
    refresh();
    for (int k = 0; k < 3; k++) begin
      step(re);
      total++;
      if (re !== '0) begin bad++; $display("FAIL me_disabled[%0d]: ch_re=%b want 0000", k, re); end
    end
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) ch_mask = 4'b1010;
      expect_word(seq[k], mk(0, seq[k], k / 2 % 2));
      step(re);
      total++;
      if (re !== (4'b0001 << seq[k])) begin
        bad++;
        $display("FAIL me_grant[%0d]: ch_re=%b want ch%0d", k, re, seq[k]);
      end
      total++;
      if (lk_b !== 1'b0) begin bad++; $display("FAIL me_locked[%0d]: locked=%b want 0", k, lk_b); end
    end
    step(re);
    total++;
    if (re !== '0) begin bad++; $display("FAIL me_empty: ch_re=%b want 0000", re); end
    check_drained("me");
    use_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet();
    test_backpressure();
    test_stall();
    test_async_reset();
    test_mask_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
